// File: rtl/iic_read8.sv
// rtl/iic_read8.sv - I2C byte receiver: 8 bits MSB-first from SDA, then ACK/NACK in the 9th clock.
// Optional running CRC-8 over received bits when IIC_READ8_CRC_EN is defined.
module iic_read8 #(
  parameter logic [7:0] CRC_POLY = 8'h31,
  parameter logic [7:0] CRC_INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ack_en,
  input  logic       scl_hs,
  input  logic       scl_lc,
  inout  tri         sda,
  output logic       busy,
  output logic       done,
  output logic [7:0] rx_data,
  input  logic       crc_clr,
  output logic [7:0] crc_out,
  output logic       crc_ok
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ACK_DRV, S_ACK_HI} state_t;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_bcnt;
  logic [7:0] r_shreg;
  logic [7:0] r_rx;
  logic       r_ack;
  logic       r_sda_low;
  logic       r_done;
  logic       w_hs;
  logic       w_lc;
  logic       w_sda_in;
  logic       w_sample;
  logic       w_finish;

  // A strobe is only usable when it is alone: no other strobe and no start pulse.
  assign w_hs     = scl_hs & ~scl_lc & ~start;
  assign w_lc     = scl_lc & ~scl_hs & ~start;
  assign w_sda_in = sda;
  assign sda      = r_sda_low ? 1'b0 : 1'bz;

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign rx_data = r_rx;

  always_comb begin
    w_next   = r_state;
    w_sample = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        if (w_hs) begin
          w_sample = 1'b1;
          if (r_bcnt == 3'd0) w_next = S_ACK_DRV;
        end
      end
      S_ACK_DRV: begin
        if (w_lc) w_next = S_ACK_HI;
      end
      S_ACK_HI: begin
        if (w_lc) begin
          w_finish = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bcnt    <= 3'd7;
      r_shreg   <= 8'h00;
      r_rx      <= 8'h00;
      r_ack     <= 1'b0;
      r_sda_low <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_finish;
      if (r_state == S_IDLE && start) begin
        r_bcnt <= 3'd7;
        r_ack  <= ack_en;
      end
      if (w_sample) begin
        r_shreg[r_bcnt] <= w_sda_in;
        r_bcnt          <= r_bcnt - 3'd1;
      end
      if (r_state == S_ACK_DRV && w_lc) r_sda_low <= r_ack;
      if (w_finish) begin
        r_sda_low <= 1'b0;
        r_rx      <= r_shreg;
      end
    end
  end

`ifdef IIC_READ8_CRC_EN
  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb = r_crc[7] ^ w_sda_in;

  // The CRC keeps running across bytes so data and checksum bytes accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= CRC_INIT;
    end else if (r_state == S_IDLE && crc_clr) begin
      r_crc <= CRC_INIT;
    end else if (w_sample) begin
      r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
    end
  end

  assign crc_out = r_crc;
  assign crc_ok  = (r_crc == 8'h00);
`else
  logic w_unused;

  assign w_unused = crc_clr ^ (^CRC_POLY) ^ (^CRC_INIT);
  assign crc_out  = 8'h00;
  assign crc_ok   = 1'b1;
`endif

endmodule

// File: tb/tb_iic_read8.sv
// tb/tb_iic_read8.sv - self-checking bench for iic_read8 (table vectors, random bytes, reset and CRC cases).
module tb_iic_read8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       ack_en = 1'b0;
  logic       scl_hs = 1'b0;
  logic       scl_lc = 1'b0;
  logic       crc_clr = 1'b0;
  logic       slave_low = 1'b0;
  wire        sda;
  logic       busy;
  logic       done;
  logic [7:0] rx_data;
  logic [7:0] crc_out;
  logic       crc_ok;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [7:0] model_crc = 8'h00;

  assign sda = slave_low ? 1'b0 : 1'bz;
  pullup (sda);

  iic_read8 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ack_en(ack_en),
    .scl_hs(scl_hs), .scl_lc(scl_lc), .sda(sda),
    .busy(busy), .done(done), .rx_data(rx_data),
    .crc_clr(crc_clr), .crc_out(crc_out), .crc_ok(crc_ok)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    bit         glitch;
    logic [7:0] exp_rx;
    logic       exp_sda9;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic hs, input logic lc, input logic st);
    scl_hs = hs;
    scl_lc = lc;
    start  = st;
    @(negedge clk);
  endtask

  // Reference CRC: polynomial division of the message, one byte at a time.
  function automatic logic [7:0] crc_byte(input logic [7:0] crc, input logic [7:0] b);
    logic [15:0] acc;
    acc = {crc ^ b, 8'h00};
    for (int k = 15; k >= 8; k--)
      if (acc[k]) acc = acc ^ (16'h131 << (k - 8));
    return acc[7:0];
  endfunction

  task automatic check_crc();
`ifdef IIC_READ8_CRC_EN
    chk("crc_model", crc_out, model_crc);
    chk("crc_ok_model", crc_ok, model_crc == 8'h00);
`else
    chk("crc_tied", crc_out, 8'h00);
    chk("crc_ok_tied", crc_ok, 1'b1);
`endif
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic ack, input bit glitch,
                         input bit clr_busy, input logic [7:0] exp_rx, input logic exp_sda9);
    int d0;
    d0 = done_cnt;
    ack_en = ack;
    tick(0, 0, 1);
    ack_en = ~ack;
    chk("busy_start", busy, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      slave_low = ~b[i];
      tick(0, 1, 0);
      tick(0, 0, 0);
      if (glitch && i == 4) begin
        tick(0, 0, 1);
        tick(1, 1, 0);
        tick(0, 0, 0);
      end
      if (clr_busy && i == 3) crc_clr = 1'b1;
      tick(1, 0, 0);
      crc_clr = 1'b0;
      if (b[i]) chk("shift_sda_released", sda, 1'b1);
      tick(0, 0, 0);
    end
    slave_low = 1'b0;
    tick(0, 1, 0);
    tick(0, 0, 0);
    tick(1, 0, 0);
    chk("ack_sda", sda, exp_sda9);
    chk("no_early_done", done, 1'b0);
    tick(0, 0, 0);
    tick(0, 1, 0);
    chk("done_pulse", done, 1'b1);
    chk("busy_at_done", busy, 1'b0);
    chk("rx_data", rx_data, exp_rx);
    chk("sda_after", sda, 1'b1);
    tick(0, 0, 0);
    chk("done_one_cycle", done, 1'b0);
    chk("done_count", done_cnt - d0, 1);
    model_crc = crc_byte(model_crc, b);
    check_crc();
  endtask

  task automatic clear_crc();
    crc_clr = 1'b1;
    tick(0, 0, 0);
    crc_clr = 1'b0;
`ifdef IIC_READ8_CRC_EN
    model_crc = 8'h00;
`endif
    check_crc();
  endtask

  task automatic partial_then_reset(input logic [7:0] b, input bit to_ack);
    ack_en = 1'b1;
    tick(0, 0, 1);
    for (int i = 7; i >= (to_ack ? 0 : 4); i--) begin
      slave_low = ~b[i];
      tick(0, 1, 0);
      tick(1, 0, 0);
    end
    slave_low = 1'b0;
    if (to_ack) begin
      tick(0, 1, 0);
      chk("ack_driven", sda, 1'b0);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("rst_sda", sda, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rx", rx_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    model_crc = 8'h00;
    check_crc();
  endtask

  vec_t vecs[$];

  initial begin
    vecs.push_back('{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b0});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b0});

    tick(0, 0, 0);
    tick(0, 0, 0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_rx", rx_data, 8'h00);
    chk("reset_sda", sda, 1'b1);
    check_crc();
    rst_n = 1'b1;
    tick(0, 0, 0);
    tick(1, 0, 0);
    tick(0, 1, 0);
    chk("idle_ignores_strobes", busy, 1'b0);

    foreach (vecs[i])
      rx_byte(vecs[i].data, vecs[i].ack, vecs[i].glitch, 1'b0, vecs[i].exp_rx, vecs[i].exp_sda9);

    for (int n = 0; n < 20; n++) begin
      logic [7:0] rb;
      logic       ra;
      rb = 8'($urandom_range(0, 255));
      ra = 1'($urandom_range(0, 1));
      rx_byte(rb, ra, 1'($urandom_range(0, 1)), 1'b0, rb, ~ra);
    end

    clear_crc();
    rx_byte(8'h68, 1'b1, 1'b0, 1'b0, 8'h68, 1'b0);
    rx_byte(8'h3A, 1'b1, 1'b0, 1'b0, 8'h3A, 1'b0);
`ifdef IIC_READ8_CRC_EN
    chk("crc_683a", crc_out, 8'h7C);
`endif
    rx_byte(8'h7C, 1'b0, 1'b0, 1'b0, 8'h7C, 1'b1);
    chk("crc_ok_after_checksum", crc_ok, 1'b1);

    clear_crc();
    rx_byte(8'hDC, 1'b1, 1'b0, 1'b1, 8'hDC, 1'b0);
`ifdef IIC_READ8_CRC_EN
    chk("crc_dc", crc_out, 8'h79);
`endif

    partial_then_reset(8'hA5, 1'b0);
    rx_byte(8'hFF, 1'b1, 1'b0, 1'b0, 8'hFF, 1'b0);
    partial_then_reset(8'h81, 1'b1);
    rx_byte(8'h42, 1'b0, 1'b1, 1'b0, 8'h42, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
